// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell plus a carry
// flop, processing WIDTH-bit operands LSB-first with a start/busy/done handshake.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] r_shift;

  // The single full-adder cell shared by every bit position.
  always_comb begin
    sum_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
    carry_nxt = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
    r_shift   = {sum_bit, r_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      r_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      r_q      <= r_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    r_d      = r_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        // Subtraction runs as a + ~b + 1: invert B and preset the carry.
        if (start) begin
          sa_d    = a;
          sb_d    = b ^ {WIDTH{sub}};
          c_d     = sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        c_d   = carry_nxt;
        r_d   = r_shift;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // On the MSB, c_q is the carry into the MSB, so overflow needs no extra flop.
        if (cnt_q == CNT_LAST) begin
          result_d = r_shift;
          cout_d   = carry_nxt;
          ovf_d    = c_q ^ carry_nxt;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized bench for serial_addsub at WIDTH=8 and WIDTH=4,
// checked against an arithmetic reference model.
module tb_serial_addsub;

  logic       clk;
  logic       reset_n;

  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, result8;

  logic       start4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, result4;

  int n_cmp = 0;
  int n_err = 0;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular and signed integer arithmetic.
  function automatic void model(input int w, input int av, input int bv, input bit s,
                                output int res, output bit co, output bit ov);
    int m, raw, sa, sb, sr;
    m   = 1 << w;
    raw = s ? av - bv : av + bv;
    res = ((raw % m) + m) % m;
    co  = s ? (av >= bv) : (raw >= m);
    sa  = (av >= m / 2) ? av - m : av;
    sb  = (bv >= m / 2) ? bv - m : bv;
    sr  = s ? sa - sb : sa + sb;
    ov  = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                     input bit ign, output logic [7:0] r_o, output logic c_o, output logic v_o);
    int  busy_n, done_n, mres;
    bit  mco, mov;
    busy_n = 0;
    done_n = 0;
    r_o = '0; c_o = 1'b0; v_o = 1'b0;
    @(negedge clk);
    a8 = av; b8 = bv; sub8 = s; start8 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      end
      if (ign && k == 4) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      if (ign && k == 5) start8 = 1'b0;
      if (ign && k == 9) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      busy_n += int'(busy8);
      done_n += int'(done8);
      if (k < 9) chk("done_early8", 32'(done8), 32'(0));
      else begin
        chk("done_pulse8", 32'(done8), 32'(1));
        r_o = result8; c_o = cout8; v_o = ovf8;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    chk("busy_fall8", 32'(busy8), 32'(0));
    chk("done_fall8", 32'(done8), 32'(0));
    chk("result_hold8", 32'(result8), 32'(r_o));
    chk("busy_len8", 32'(busy_n), 32'(9));
    chk("done_cnt8", 32'(done_n), 32'(1));
    model(8, int'(av), int'(bv), s, mres, mco, mov);
    chk("model_res8", 32'(r_o), 32'(mres));
    chk("model_cout8", 32'(c_o), 32'(mco));
    chk("model_ovf8", 32'(v_o), 32'(mov));
    if (ign) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("ign_no_restart", 32'({busy8, done8}), 32'(0));
      end
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       c, v;
    logic [8:0] iv;
    int         d_cnt, d_pos, mres;
    bit         mco, mov;
    logic [3:0] cap_r;
    logic       cap_c, cap_v, cur_s;
    logic [3:0] cur_a, cur_b;

    reset_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    chk("rst_result", 32'(result8), 32'(0));
    chk("rst_flags", 32'({cout8, ovf8}), 32'(0));
    reset_n = 1'b1;

    op8(8'h35, 8'h1A, 1'b0, 1'b0, r, c, v);
    chk("add_res", 32'(r), 32'h4F);
    chk("add_flags", 32'({c, v}), 32'(2'b00));
    op8(8'h7F, 8'h01, 1'b0, 1'b0, r, c, v);
    chk("ovf_res", 32'(r), 32'h80);
    chk("ovf_flags", 32'({c, v}), 32'(2'b01));
    op8(8'hFF, 8'h01, 1'b0, 1'b0, r, c, v);
    chk("wrap_res", 32'(r), 32'h00);
    chk("wrap_flags", 32'({c, v}), 32'(2'b10));
    op8(8'h05, 8'h07, 1'b1, 1'b0, r, c, v);
    chk("sub_res", 32'(r), 32'hFE);
    chk("sub_flags", 32'({c, v}), 32'(2'b00));
    op8(8'h80, 8'h01, 1'b1, 1'b0, r, c, v);
    chk("subovf_res", 32'(r), 32'h7F);
    chk("subovf_flags", 32'({c, v}), 32'(2'b11));

    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, r, c, v);

    op8(8'h10, 8'h20, 1'b0, 1'b1, r, c, v);
    chk("ign_res", 32'(r), 32'h30);

    // Abort mid-operation: reset lands between edges after bit 4.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'(0));
    chk("abort_done", 32'(done8), 32'(0));
    chk("abort_result", 32'(result8), 32'(0));
    chk("abort_flags", 32'({cout8, ovf8}), 32'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_quiet", 32'({busy8, done8}), 32'(0));
    end
    reset_n = 1'b1;
    op8(8'h01, 8'h01, 1'b0, 1'b0, r, c, v);
    chk("post_abort_res", 32'(r), 32'h02);

    // WIDTH=4 exhaustive sweep with start held high back-to-back.
    @(negedge clk);
    cur_a = 4'h0; cur_b = 4'h0; cur_s = 1'b0;
    a4 = cur_a; b4 = cur_b; sub4 = cur_s; start4 = 1'b1;
    for (int idx = 0; idx < 512; idx++) begin
      d_cnt = 0; d_pos = 0;
      cap_r = '0; cap_c = 1'b0; cap_v = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) begin
          if (idx < 511) begin
            iv = 9'(idx + 1);
            a4 = iv[7:4]; b4 = iv[3:0]; sub4 = iv[8];
          end else start4 = 1'b0;
        end
        if (done4) begin
          d_cnt++; d_pos = k;
          cap_r = result4; cap_c = cout4; cap_v = ovf4;
        end
      end
      model(4, int'(cur_a), int'(cur_b), cur_s, mres, mco, mov);
      chk("w4_done_cnt", 32'(d_cnt), 32'(1));
      chk("w4_done_pos", 32'(d_pos), 32'(5));
      chk("w4_res", 32'(cap_r), 32'(mres));
      chk("w4_cout", 32'(cap_c), 32'(mco));
      chk("w4_ovf", 32'(cap_v), 32'(mov));
      iv = 9'(idx + 1);
      cur_a = iv[7:4]; cur_b = iv[3:0]; cur_s = iv[8];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
